// File: rtl/pico_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pico_mem_pkg
// Purpose : Shared widths and state encoding for the PicoComputer data-memory
//           path. The CPU core, the memory and mem_master all reuse these.
// Contents: ADDR_W  - memory address width (64 words)
//           DATA_W  - memory word width
//           LEN_W   - burst-length field width (1..8 beats)
//           mem_state_t - mem_master controller states
// Revision: 1.0 - initial release
// ============================================================================
package pico_mem_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      ISSUE = 3'd2,
      CAPT  = 3'd3,
      RESP  = 3'd4
   } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// ============================================================================
// Module  : mem_master
// Purpose : Initiator-side controller for the 64x16 single-port data memory.
//           Accepts load/store requests over valid/ready, drives the memory
//           we/addr/data pins and returns read words (single or burst of up
//           to 8) on a response channel with backpressure.
// Ports   : clk, rst_n                - clock, synchronous active-low reset
//           req_valid/req_ready       - request handshake
//           req_we/req_addr/req_wdata/req_len - request payload
//           rsp_valid/rsp_ready       - response handshake
//           rsp_data/rsp_last         - read word, last-beat flag
//           busy                      - controller not in IDLE
//           mem_we/mem_addr/mem_data  - memory write enable/address/data
//           mem_out                   - memory read data (one cycle latency)
// Revision: 1.0 - initial release
// ============================================================================
module mem_master
   import pico_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_out
);

   mem_state_t        state;
   mem_state_t        state_n;
   logic [LEN_W-1:0]  r_beats;      // beats remaining after the current one
   logic              w_accept;
   logic              w_last_beat;
   logic              w_advance;

   assign req_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign w_accept    = req_valid && (state == IDLE);
   assign w_last_beat = (r_beats == '0);
   assign w_advance   = (state == RESP) && rsp_ready && !w_last_beat;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (req_valid) state_n = req_we ? WRITE : ISSUE;
         WRITE:   state_n = IDLE;
         ISSUE:   state_n = CAPT;
         CAPT:    state_n = RESP;
         RESP:    if (rsp_ready) state_n = w_last_beat ? IDLE : ISSUE;
         default: state_n = IDLE;
      endcase
   end

   // mem_addr doubles as the beat address register: it is loaded on accept
   // and stepped (mod 2^ADDR_W) only when a non-final beat is consumed, so it
   // stays stable for the whole of a stalled RESP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         r_beats   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_last  <= 1'b0;
      end else begin
         state     <= state_n;
         // Outputs are registered from the next state so they line up with it.
         mem_we    <= (state_n == WRITE);
         rsp_valid <= (state_n == RESP);
         if (w_accept) begin
            mem_addr <= req_addr;
            mem_data <= req_wdata;
            r_beats  <= req_len;
         end
         // Memory returns the ISSUE-cycle address's word during CAPT.
         if (state == CAPT) begin
            rsp_data <= mem_out;
            rsp_last <= w_last_beat;
         end
         if (w_advance) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            r_beats  <= r_beats - LEN_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_master.md
# mem_master

Initiator-side controller for the 64×16 single-port data memory of the PicoComputer CPU. It accepts load/store requests from the CPU core over a valid/ready handshake and drives the memory's `we`/`addr`/`data` inputs. Read data coming back on the memory's `out` port is returned to the core on a response channel with backpressure. The block supports single-word writes, plus single or burst reads of up to 8 consecutive words.

## Interface
- `ADDR_W`, 6: memory address width (64 words).
- `DATA_W`, 16: memory word width.
- `LEN_W`, 3: burst-length field width; a read returns `req_len+1` words (1..8).

- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: start address.
- `req_wdata` in DATA_W: write data (write requests only).
- `req_len` in LEN_W: beats minus one (reads only; ignored for writes).
- `rsp_valid` out 1: read word available.
- `rsp_ready` in 1: core consumes the word when `rsp_valid && rsp_ready`.
- `rsp_data` out DATA_W: read word.
- `rsp_last` out 1: high with the final word of a burst.
- `busy` out 1: high in any state other than IDLE.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_data` out DATA_W: memory write data.
- `mem_out` in DATA_W: memory read data. The memory registers it, so data for the address presented in cycle N is valid in cycle N+1.

## Operation
- States: IDLE, WRITE, ISSUE, CAPT, RESP.
- IDLE:
  - `req_ready`=1 only in IDLE.
  - On handshake, latch `req_addr`, `req_wdata`, `req_len` into internal registers.
  - Next state is WRITE if `req_we`=1, else ISSUE.
- WRITE:
  - `mem_we`=1, with `mem_addr`/`mem_data` taken from the latched request.
  - The memory writes at the end of this cycle.
  - Next state is IDLE. No response is generated.
- ISSUE:
  - `mem_we`=0, `mem_addr` = current beat address.
  - Next state is CAPT.
- CAPT:
  - `rsp_data` <= `mem_out` at the end of the cycle.
  - `rsp_last` <= (remaining beat count == 0).
  - Next state is RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_last` are held stable.
  - On `rsp_ready`=1: if this beat is the last, go to IDLE. Otherwise increment the address modulo 2^ADDR_W (63 → 0), decrement the beat count, and go to ISSUE.
  - On `rsp_ready`=0: stay in RESP. Address and count do not change.
- `mem_we` is high only in WRITE. A read never disturbs memory contents.
- The beat counter is LEN_W bits wide and counts down from the latched `req_len` to 0. Wrap-around is legal and applies to the address only.
- Reset (`rst_n`=0 at a rising edge), including in the middle of a burst:
  - Next state is IDLE and any remaining beats are discarded.
  - Outputs take these values: `mem_we`=0, `mem_addr`=0, `mem_data`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `busy`=0, `req_ready`=1.
- Because `req_ready`=0 outside IDLE, a request raised while busy stays pending; the core must hold it stable.

## Timing
- Handshake in cycle T:
  - Write: `mem_we` is high in T+1, the memory is updated at the edge ending T+1, and `req_ready` is high again in T+2.
  - Read: address on `mem_addr` in T+1, `rsp_valid` rises in T+3. With `rsp_ready` held at 1, each beat takes 3 cycles, so a burst of n words occupies T+1 through T+3n.
- A read issued in the cycle immediately after a write (to the same address) returns the new data.
- `req_ready` and `busy` are decoded combinationally from the state register. All other outputs are registered.

## Structure
- Shared package `pico_mem_pkg` holds:
  - constants ADDR_W=6, DATA_W=16, LEN_W=3;
  - the state enum `mem_state_t` {IDLE, WRITE, ISSUE, CAPT, RESP}.
  - The CPU core and the memory reuse these widths.
- Single module with no sub-modules. The FSM, the address/beat counters and the response register are all in `mem_master`.

## Test plan
- Write 0xBEEF to address 5 (handshake at T), then read address 5 with len 0 → `mem_we` high only in T+1; `rsp_valid`=1, `rsp_data`=0xBEEF and `rsp_last`=1 three cycles after the read handshake.
- Preload addresses 62, 63, 0, 1 with 0x1111, 0x2222, 0x3333, 0x4444; read from 62 with `req_len`=3 → four responses in that order, `rsp_last` only on 0x4444, and `mem_addr` sequence 62, 63, 0, 1.
- Read burst with `rsp_ready` held low for 5 cycles on beat 2 → `rsp_valid`, `rsp_data` and `mem_addr` all stable throughout; the burst then completes with correct data.
- `req_valid` held high during a burst → `req_ready`=0 until IDLE; the request is accepted in the first IDLE cycle.
- `rst_n` pulsed low during CAPT of beat 3 of an 8-beat burst → next cycle is IDLE with every output at its reset value; no further responses appear and memory contents are unchanged.
- Write with `req_len`=7 → exactly one `mem_we` cycle, one word modified, and no response.
